// File: rtl/axis_image_framer.sv
// axis_image_framer
//   Parses a 12-byte little-endian image header (rows, cols, channels) from an
//   8-bit AXI-Stream, validates it, then packs the following pixel bytes into
//   BYTES_PER_BEAT-wide output beats. Beats never cross a line boundary: the
//   last beat of a line may be short, with unused lanes zeroed and tkeep
//   cleared for them. tuser marks the first beat of a frame; tlast marks end
//   of line (TLAST_MODE=0) or end of frame (TLAST_MODE=1).
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   s_axis_tdata    header/pixel byte in
//   s_axis_tvalid   input byte valid
//   s_axis_tready   input byte ready
//   m_axis_tdata    packed output beat, first byte in [7:0]
//   m_axis_tkeep    byte enables, contiguous from bit 0
//   m_axis_tvalid   output beat valid
//   m_axis_tlast    end of line / end of frame marker
//   m_axis_tuser    first beat of frame
//   m_axis_tready   downstream ready
//   frame_done      one-cycle pulse after the last beat of a frame is taken
//   hdr_error       sticky, set when a header fails validation
//   frame_count     number of completed frames, wraps at 16 bits

module axis_image_framer #(
  parameter int BYTES_PER_BEAT = 4,
  parameter int DIM_WIDTH      = 16,
  parameter int MAX_ROWS       = 4096,
  parameter int MAX_COLS       = 4096,
  parameter int MAX_CHANNELS   = 4,
  parameter int TLAST_MODE     = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [8*BYTES_PER_BEAT-1:0] m_axis_tdata,
  output logic [BYTES_PER_BEAT-1:0]   m_axis_tkeep,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser,
  input  logic                        m_axis_tready,
  output logic                        frame_done,
  output logic                        hdr_error,
  output logic [15:0]                 frame_count
);

  localparam int IDX_W  = (BYTES_PER_BEAT > 1) ? $clog2(BYTES_PER_BEAT) : 1;
  localparam int LB_W   = 2 * DIM_WIDTH;
  localparam int DATA_W = 8 * BYTES_PER_BEAT;
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(BYTES_PER_BEAT - 1);
  localparam logic [3:0]       HDR_LAST  = 4'd11;
  localparam bit               LAST_PER_FRAME = (TLAST_MODE != 0);

  typedef enum logic [1:0] {
    ST_HDR   = 2'd0,
    ST_CHECK = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3   // final beat of the frame is pending; input blocked
  } state_t;

  // A header field is rejected when zero, above its maximum, or carrying
  // bits the dimension registers cannot hold.
  function automatic logic field_bad(input logic [31:0] v, input logic [31:0] max_v);
    return (v == 32'd0) || (v > max_v) || ((v >> DIM_WIDTH) != 32'd0);
  endfunction

  state_t state_q, state_d;

  logic [95:0]          hdr_q, hdr_d;
  logic [3:0]           hdr_idx_q, hdr_idx_d;
  logic [DIM_WIDTH-1:0] rows_q, rows_d;
  logic [LB_W-1:0]      line_bytes_q, line_bytes_d;
  logic [LB_W-1:0]      col_cnt_q, col_cnt_d;
  logic [DIM_WIDTH-1:0] row_cnt_q, row_cnt_d;
  logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
  logic [DATA_W-1:0]    acc_q, acc_d;
  logic                 sof_q, sof_d;

  logic [DATA_W-1:0]         m_tdata_q, m_tdata_d;
  logic [BYTES_PER_BEAT-1:0] m_tkeep_q, m_tkeep_d;
  logic                      m_tvalid_q, m_tvalid_d;
  logic                      m_tlast_q, m_tlast_d;
  logic                      m_tuser_q, m_tuser_d;
  logic                      frame_done_q, frame_done_d;
  logic                      hdr_error_q, hdr_error_d;
  logic [15:0]               frame_count_q, frame_count_d;

  logic                      s_ready;
  logic                      in_fire;
  logic                      out_fire;
  logic [31:0]               hdr_rows, hdr_cols, hdr_ch;
  logic                      hdr_ok;
  logic                      eol;
  logic                      last_row;
  logic                      beat_done;
  logic [DATA_W-1:0]         beat_data;
  logic [BYTES_PER_BEAT-1:0] keep_mask;

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  assign hdr_rows = hdr_q[31:0];
  assign hdr_cols = hdr_q[63:32];
  assign hdr_ch   = hdr_q[95:64];
  assign hdr_ok   = !field_bad(hdr_rows, 32'(MAX_ROWS)) &&
                    !field_bad(hdr_cols, 32'(MAX_COLS)) &&
                    !field_bad(hdr_ch,   32'(MAX_CHANNELS));

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign s_axis_tready = s_ready && !reset;
  assign in_fire       = s_axis_tvalid && s_axis_tready;
  assign out_fire      = m_tvalid_q && m_axis_tready;

  assign eol       = (col_cnt_q == (line_bytes_q - LB_W'(1)));
  assign last_row  = (row_cnt_q == (rows_q - DIM_WIDTH'(1)));
  assign beat_done = (byte_idx_q == LAST_LANE) || eol;

  // Current accumulator with the incoming byte dropped into its lane. Lanes
  // above byte_idx are still zero because the accumulator clears per beat.
  always_comb begin
    beat_data = acc_q;
    beat_data[{byte_idx_q, 3'b000} +: 8] = s_axis_tdata;
  end

  for (genvar gi = 0; gi < BYTES_PER_BEAT; gi++) begin : g_keep
    assign keep_mask[gi] = (byte_idx_q >= IDX_W'(gi));
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_HDR;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HDR: begin
        if (in_fire && (hdr_idx_q == HDR_LAST)) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_d = hdr_ok ? ST_DATA : ST_HDR;
      end
      ST_DATA: begin
        if (in_fire && eol && last_row) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_fire) begin
          state_d = ST_HDR;
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // In DATA, ready looks straight through to m_axis_tready so a beat can be
  // completed in the same cycle the previous one is taken (no bubble).
  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      ST_HDR:  s_ready = 1'b1;
      ST_DATA: s_ready = !m_tvalid_q || m_axis_tready;
      default: s_ready = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    hdr_d         = hdr_q;
    hdr_idx_d     = hdr_idx_q;
    rows_d        = rows_q;
    line_bytes_d  = line_bytes_q;
    col_cnt_d     = col_cnt_q;
    row_cnt_d     = row_cnt_q;
    byte_idx_d    = byte_idx_q;
    acc_d         = acc_q;
    sof_d         = sof_q;
    m_tdata_d     = m_tdata_q;
    m_tkeep_d     = m_tkeep_q;
    m_tvalid_d    = m_tvalid_q;
    m_tlast_d     = m_tlast_q;
    m_tuser_d     = m_tuser_q;
    frame_done_d  = 1'b0;
    hdr_error_d   = hdr_error_q;
    frame_count_d = frame_count_q;

    // A taken beat drops valid; a beat completing this same cycle re-asserts
    // it further down.
    if (out_fire) begin
      m_tvalid_d = 1'b0;
    end

    case (state_q)
      ST_HDR: begin
        if (in_fire) begin
          hdr_d[{hdr_idx_q, 3'b000} +: 8] = s_axis_tdata;
          hdr_idx_d = (hdr_idx_q == HDR_LAST) ? 4'd0 : hdr_idx_q + 4'd1;
        end
      end

      ST_CHECK: begin
        if (!hdr_ok) begin
          hdr_error_d = 1'b1;
        end else begin
          rows_d       = hdr_rows[DIM_WIDTH-1:0];
          line_bytes_d = LB_W'(hdr_cols[DIM_WIDTH-1:0]) * LB_W'(hdr_ch[DIM_WIDTH-1:0]);
          col_cnt_d    = '0;
          row_cnt_d    = '0;
          byte_idx_d   = '0;
          acc_d        = '0;
          sof_d        = 1'b1;
        end
      end

      ST_DATA: begin
        if (in_fire) begin
          if (beat_done) begin
            m_tdata_d  = beat_data;
            m_tkeep_d  = keep_mask;
            m_tvalid_d = 1'b1;
            m_tuser_d  = sof_q;
            m_tlast_d  = LAST_PER_FRAME ? (eol && last_row) : eol;
            sof_d      = 1'b0;
            acc_d      = '0;
            byte_idx_d = '0;
          end else begin
            acc_d      = beat_data;
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end

          if (eol) begin
            col_cnt_d = '0;
            row_cnt_d = row_cnt_q + DIM_WIDTH'(1);
          end else begin
            col_cnt_d = col_cnt_q + LB_W'(1);
          end
        end
      end

      ST_DRAIN: begin
        if (out_fire) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_q         <= '0;
      hdr_idx_q     <= '0;
      rows_q        <= '0;
      line_bytes_q  <= '0;
      col_cnt_q     <= '0;
      row_cnt_q     <= '0;
      byte_idx_q    <= '0;
      acc_q         <= '0;
      sof_q         <= 1'b0;
      m_tdata_q     <= '0;
      m_tkeep_q     <= '0;
      m_tvalid_q    <= 1'b0;
      m_tlast_q     <= 1'b0;
      m_tuser_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      hdr_error_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hdr_q         <= hdr_d;
      hdr_idx_q     <= hdr_idx_d;
      rows_q        <= rows_d;
      line_bytes_q  <= line_bytes_d;
      col_cnt_q     <= col_cnt_d;
      row_cnt_q     <= row_cnt_d;
      byte_idx_q    <= byte_idx_d;
      acc_q         <= acc_d;
      sof_q         <= sof_d;
      m_tdata_q     <= m_tdata_d;
      m_tkeep_q     <= m_tkeep_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tlast_q     <= m_tlast_d;
      m_tuser_q     <= m_tuser_d;
      frame_done_q  <= frame_done_d;
      hdr_error_q   <= hdr_error_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tkeep  = m_tkeep_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tuser  = m_tuser_q;
  assign frame_done    = frame_done_q;
  assign hdr_error     = hdr_error_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_axis_image_framer.sv
// Directed testbench for axis_image_framer. Two instances share the input
// stream: dut0 uses tlast per line, dut1 uses tlast per frame. Accepted beats
// are captured into queues and compared against hand-computed values.

module tb_axis_image_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0;
  logic        m_tready = 1'b1;

  logic        s_tready0, s_tready1;
  logic [31:0] m_tdata0, m_tdata1;
  logic [3:0]  m_tkeep0, m_tkeep1;
  logic        m_tvalid0, m_tvalid1, m_tlast0, m_tlast1, m_tuser0, m_tuser1;
  logic        frame_done0, frame_done1, hdr_error0, hdr_error1;
  logic [15:0] frame_count0, frame_count1;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  int    fd0 = 0;
  int    n_checks = 0;
  int    n_pass = 0;

  axis_image_framer #(.BYTES_PER_BEAT(4), .TLAST_MODE(0)) dut0 (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready0),
    .m_axis_tdata(m_tdata0), .m_axis_tkeep(m_tkeep0), .m_axis_tvalid(m_tvalid0),
    .m_axis_tlast(m_tlast0), .m_axis_tuser(m_tuser0), .m_axis_tready(m_tready),
    .frame_done(frame_done0), .hdr_error(hdr_error0), .frame_count(frame_count0)
  );

  axis_image_framer #(.BYTES_PER_BEAT(4), .TLAST_MODE(1)) dut1 (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready1),
    .m_axis_tdata(m_tdata1), .m_axis_tkeep(m_tkeep1), .m_axis_tvalid(m_tvalid1),
    .m_axis_tlast(m_tlast1), .m_axis_tuser(m_tuser1), .m_axis_tready(m_tready),
    .frame_done(frame_done1), .hdr_error(hdr_error1), .frame_count(frame_count1)
  );

  // Beat capture and frame_done pulse counting.
  always @(posedge clk) begin
    if (m_tvalid0 && m_tready) begin
      q0.push_back({m_tdata0, m_tkeep0, m_tlast0, m_tuser0});
      $display("[%0t] beat data=%08h keep=%04b last=%0d user=%0d",
               $time, m_tdata0, m_tkeep0, m_tlast0, m_tuser0);
    end
    if (m_tvalid1 && m_tready) begin
      q1.push_back({m_tdata1, m_tkeep1, m_tlast1, m_tuser1});
    end
    if (frame_done0) begin
      fd0 <= fd0 + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all start and end on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      done = s_tready0;
      @(negedge clk);
    end
    if (!done) begin
      n_checks++;
      $display("FAIL send_byte_timeout byte=%02h got ready=%0d want 1", b, s_tready0);
    end
  endtask

  task automatic send_header(input logic [31:0] rows, input logic [31:0] cols,
                             input logic [31:0] ch);
    logic [95:0] hdr;
    hdr = {ch, cols, rows};
    for (int i = 0; i < 12; i++) begin
      send_byte(hdr[8*i +: 8]);
    end
  endtask

  task automatic send_bytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      send_byte(base + 8'(i));
    end
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({s_tready0, s_tready1, m_tvalid0, m_tkeep0, frame_done0, hdr_error0} !== 9'b0 ||
        frame_count0 !== 16'd0 || m_tdata0 !== 32'd0)
      $display("FAIL reset_outputs got rdy=%0d vld=%0d keep=%b err=%0d cnt=%0d want all 0",
               s_tready0, m_tvalid0, m_tkeep0, hdr_error0, frame_count0);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (s_tready0 !== 1'b1) $display("FAIL reset_hdr_ready got %0d want 1", s_tready0);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_line_mode();
    beat_t want[2];
    beat_t got;
    int    fd_start;
    want[0] = {32'h00131211, 4'b0111, 1'b1, 1'b1};
    want[1] = {32'h00161514, 4'b0111, 1'b1, 1'b0};
    q0.delete(); q1.delete();
    fd_start = fd0;
    send_header(32'd2, 32'd3, 32'd1);
    send_bytes(8'h11, 6);
    idle(4);
    n_checks++;
    if (q0.size() != 2) $display("FAIL t1_beat_count got %0d want 2", q0.size());
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      got = (i < q0.size()) ? q0[i] : beat_t'(0);
      n_checks++;
      if (got !== want[i]) $display("FAIL t1_beat%0d got %h want %h", i, got, want[i]);
      else n_pass++;
    end
    n_checks++;
    if (q1.size() != 2 || q1[0].last !== 1'b0 || q1[1].last !== 1'b1)
      $display("FAIL t1_frame_mode_tlast got n=%0d want 2 beats with last 0,1", q1.size());
    else n_pass++;
    n_checks++;
    if (fd0 - fd_start != 1) $display("FAIL t1_frame_done_pulses got %0d want 1", fd0 - fd_start);
    else n_pass++;
    n_checks++;
    if (frame_count0 !== 16'd1) $display("FAIL t1_frame_count got %0d want 1", frame_count0);
    else n_pass++;
  endtask

  task automatic test_frame_mode();
    beat_t want[3];
    beat_t got;
    want[0] = {32'h33323130, 4'b1111, 1'b0, 1'b1};
    want[1] = {32'h37363534, 4'b1111, 1'b0, 1'b0};
    want[2] = {32'h00003938, 4'b0011, 1'b1, 1'b0};
    q0.delete(); q1.delete();
    send_header(32'd1, 32'd5, 32'd2);
    send_bytes(8'h30, 10);
    idle(4);
    n_checks++;
    if (q1.size() != 3) $display("FAIL t2_beat_count got %0d want 3", q1.size());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      got = (i < q1.size()) ? q1[i] : beat_t'(0);
      n_checks++;
      if (got !== want[i]) $display("FAIL t2_beat%0d got %h want %h", i, got, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    beat_t want[2];
    beat_t got;
    bit    seen;
    want[0] = {32'h24232221, 4'b1111, 1'b0, 1'b1};
    want[1] = {32'h28272625, 4'b1111, 1'b1, 1'b0};
    q0.delete(); q1.delete();
    seen = 1'b0;
    fork
      begin
        send_header(32'd1, 32'd8, 32'd1);
        send_bytes(8'h21, 8);
      end
      begin
        for (int i = 0; i < 100 && !seen; i++) begin
          @(negedge clk);
          seen = m_tvalid0;
        end
        m_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          #1;
          n_checks++;
          if (m_tvalid0 !== 1'b1 || m_tdata0 !== 32'h24232221 || s_tready0 !== 1'b0)
            $display("FAIL t3_stall_c%0d got vld=%0d data=%08h rdy=%0d want 1 24232221 0",
                     c, m_tvalid0, m_tdata0, s_tready0);
          else n_pass++;
        end
        @(negedge clk);
        m_tready = 1'b1;
      end
    join
    idle(4);
    n_checks++;
    if (q0.size() != 2) $display("FAIL t3_beat_count got %0d want 2", q0.size());
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      got = (i < q0.size()) ? q0[i] : beat_t'(0);
      n_checks++;
      if (got !== want[i]) $display("FAIL t3_beat%0d got %h want %h", i, got, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_bad_header();
    beat_t want;
    beat_t got;
    want = {32'h44434241, 4'b1111, 1'b1, 1'b1};
    q0.delete(); q1.delete();
    send_header(32'd2, 32'd0, 32'd1);
    idle(3);
    n_checks++;
    if (hdr_error0 !== 1'b1) $display("FAIL t4_cols_zero got err=%0d want 1", hdr_error0);
    else n_pass++;
    do_reset();
    send_header(32'd1, 32'd2, 32'd5);
    idle(3);
    n_checks++;
    if (hdr_error0 !== 1'b1) $display("FAIL t4_channels_5 got err=%0d want 1", hdr_error0);
    else n_pass++;
    do_reset();
    send_header(32'd1, 32'h0001_0002, 32'd1);
    n_checks++;
    #1;
    if (s_tready0 !== 1'b0) $display("FAIL t4_check_not_ready got %0d want 0", s_tready0);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (hdr_error0 !== 1'b1) $display("FAIL t4_cols_high_bit got err=%0d want 1", hdr_error0);
    else n_pass++;
    n_checks++;
    if (q0.size() != 0) $display("FAIL t4_no_beats got %0d want 0", q0.size());
    else n_pass++;
    // channels at its maximum is accepted
    send_header(32'd1, 32'd1, 32'd4);
    send_bytes(8'h41, 4);
    idle(4);
    got = (q0.size() > 0) ? q0[0] : beat_t'(0);
    n_checks++;
    if (q0.size() != 1 || got !== want)
      $display("FAIL t4_valid_after_bad got n=%0d beat=%h want 1 beat %h", q0.size(), got, want);
    else n_pass++;
    n_checks++;
    if (hdr_error0 !== 1'b1) $display("FAIL t4_error_sticky got %0d want 1", hdr_error0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    beat_t want;
    beat_t got;
    want = {32'h54535251, 4'b1111, 1'b1, 1'b1};
    send_header(32'd2, 32'd2, 32'd1);
    send_bytes(8'h61, 3);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({s_tready0, m_tvalid0, m_tlast0, m_tuser0, frame_done0, hdr_error0} !== 6'b0 ||
        m_tdata0 !== 32'd0 || m_tkeep0 !== 4'd0 || frame_count0 !== 16'd0)
      $display("FAIL t5_async_clear got rdy=%0d data=%08h keep=%b err=%0d cnt=%0d want all 0",
               s_tready0, m_tdata0, m_tkeep0, hdr_error0, frame_count0);
    else n_pass++;
    s_tvalid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    q0.delete(); q1.delete();
    send_header(32'd1, 32'd4, 32'd1);
    send_bytes(8'h51, 4);
    idle(4);
    got = (q0.size() > 0) ? q0[0] : beat_t'(0);
    n_checks++;
    if (q0.size() != 1 || got !== want)
      $display("FAIL t5_fresh_frame got n=%0d beat=%h want 1 beat %h", q0.size(), got, want);
    else n_pass++;
    n_checks++;
    if (frame_count0 !== 16'd1) $display("FAIL t5_frame_count got %0d want 1", frame_count0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    beat_t want;
    beat_t got;
    int    fd_start;
    logic [7:0] base;
    q0.delete(); q1.delete();
    fd_start = fd0;
    for (int f = 0; f < 3; f++) begin
      send_header(32'd1, 32'd6, 32'd1);
      send_bytes(8'h70 + 8'(8 * f), 6);
    end
    idle(4);
    n_checks++;
    if (q0.size() != 6) $display("FAIL t6_beat_count got %0d want 6", q0.size());
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      base = 8'h70 + 8'(8 * (i / 2));
      if (i % 2 == 0)
        want = {base + 8'd3, base + 8'd2, base + 8'd1, base, 4'b1111, 1'b0, 1'b1};
      else
        want = {16'h0000, base + 8'd5, base + 8'd4, 4'b0011, 1'b1, 1'b0};
      got = (i < q0.size()) ? q0[i] : beat_t'(0);
      n_checks++;
      if (got !== want) $display("FAIL t6_beat%0d got %h want %h", i, got, want);
      else n_pass++;
    end
    n_checks++;
    if (fd0 - fd_start != 3) $display("FAIL t6_frame_done_pulses got %0d want 3", fd0 - fd_start);
    else n_pass++;
    n_checks++;
    if (frame_count0 !== 16'd4) $display("FAIL t6_frame_count got %0d want 4", frame_count0);
    else n_pass++;

    // Preload the counter to its top value and check the wrap.
    force dut0.frame_count_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut0.frame_count_q;
    @(negedge clk);
    q0.delete();
    send_header(32'd1, 32'd1, 32'd1);
    send_byte(8'h99);
    idle(4);
    want = {32'h00000099, 4'b0001, 1'b1, 1'b1};
    got = (q0.size() > 0) ? q0[0] : beat_t'(0);
    n_checks++;
    if (q0.size() != 1 || got !== want)
      $display("FAIL t6_single_byte got n=%0d beat=%h want 1 beat %h", q0.size(), got, want);
    else n_pass++;
    n_checks++;
    if (frame_count0 !== 16'd0) $display("FAIL t6_count_wrap got %0d want 0", frame_count0);
    else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_line_mode();
    test_frame_mode();
    test_backpressure();
    test_bad_header();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_image_framer.md
Name: axis_image_framer

Overview:
Synthesizable AXI-Stream image framer that replaces file-driven pixel injection with an in-fabric source. It consumes a byte stream carrying a 12-byte image header (rows, cols, channels) followed by raw pixel bytes. It emits BYTES_PER_BEAT-wide beats with tkeep, tuser on start-of-frame and tlast per line or per frame. It sits between the DMA/byte loader and the CNN input line buffers.

Parameters:
BYTES_PER_BEAT, 4, bytes packed per output beat (1..16); m_axis_tdata width = 8*BYTES_PER_BEAT.
DIM_WIDTH, 16, width of the rows/cols/channels registers; header bits above this width must be zero.
MAX_ROWS, 4096, largest accepted row count.
MAX_COLS, 4096, largest accepted column count.
MAX_CHANNELS, 4, largest accepted channel count.
TLAST_MODE, 0, 0 = tlast at end of every line, 1 = tlast only at end of frame.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
s_axis_tdata  in  8  header/pixel byte
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
m_axis_tdata  out  8*BYTES_PER_BEAT  packed bytes; first byte in [7:0]
m_axis_tkeep  out  BYTES_PER_BEAT  byte enables, contiguous from bit 0
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  end of line/frame per TLAST_MODE
m_axis_tuser  out  1  first beat of frame
m_axis_tready  in  1  downstream ready
frame_done  out  1  one-cycle pulse when the last beat of a frame is accepted
hdr_error  out  1  sticky; set on an invalid header, cleared only by reset
frame_count  out  16  count of completed frames; wraps at 0xFFFF->0

Behaviour:
- Reset, asynchronous: state=HDR; all outputs 0; the accumulator, counters, frame_count and hdr_error clear. Reset mid-frame discards partial beats with no flush.
- Handshake: a transfer occurs when valid&&ready. m_axis_* stays stable while tvalid=1 and tready=0. Input bytes are consumed only on s_axis_tvalid&&s_axis_tready.
- HDR: s_axis_tready=1. Reads 12 bytes, little-endian: rows[31:0], cols[31:0], channels[31:0]. After the 12th byte, go to CHECK.
- CHECK, one cycle, s_axis_tready=0:
  - Header is invalid if any field is 0, exceeds its MAX_*, or has nonzero bits at or above DIM_WIDTH.
  - Invalid: set hdr_error and return to HDR. The following bytes are parsed as a new header.
  - Valid: register line_bytes = cols*channels (width 2*DIM_WIDTH), clear the counters, set sof, and go to DATA.
- DATA, s_axis_tready = !m_axis_tvalid || m_axis_tready. This is a combinational path from m_axis_tready and is intentional.
  - Each accepted byte is written to accumulator lane byte_idx.
  - A beat completes when byte_idx==BYTES_PER_BEAT-1 or the byte is the last of its line.
  - On completion, the next cycle has m_axis_tvalid=1, tkeep=(1<<(byte_idx+1))-1, tuser=sof (sof then clears), and tlast=end_of_line (mode 0) or end_of_frame (mode 1). byte_idx returns to 0.
  - Latency: 1 cycle from the completing byte to m_axis_tvalid.
  - Beats never span lines. A short final beat per line has unused lanes set to 0 with tkeep=0.
  - The column byte counter wraps to 0 at line_bytes and increments row_cnt.
  - A beat completing and the previous beat being consumed in the same cycle proceeds with no bubble.
- Frame end: when the final beat (last row, last byte) is accepted, pulse frame_done, increment frame_count and return to HDR. No HDR bytes are accepted until that beat is consumed.
- Input tvalid gaps stall accumulation only; partial beats are held indefinitely.

Test Plan:
1. BPB=4, mode 0, header rows=2 cols=3 ch=1, bytes 0x11..0x16 -> two beats: tdata=0x00131211 tkeep=0111 tuser=1 tlast=1; then 0x00161514 tkeep=0111 tuser=0 tlast=1; frame_done pulse; frame_count=1.
2. BPB=4, mode 1, rows=1 cols=5 ch=2 (10 bytes) -> beats with tkeep 1111,1111,0011; only the third has tlast=1; tuser only on the first.
3. Backpressure: m_axis_tready held 0 for 5 cycles mid-frame -> s_axis_tready=0 after one beat is pending; m_axis_tdata stable; no byte lost or duplicated. Output matches an unstalled run.
4. Invalid headers: cols=0 or channels=5 -> hdr_error=1, no m_axis_tvalid. A valid header sent next is framed correctly and hdr_error remains 1.
5. Reset asserted mid-frame after 3 data bytes -> all outputs 0 immediately. After release, a fresh header and frame produce a correct stream with tuser on the first beat.
6. Back-to-back frames with continuous tvalid and tready=1 -> frame_count increments per frame; each frame's first beat has tuser=1. Preload frame_count to 0xFFFF; the next frame wraps it to 0.
